// File: rtl/genius_core_param_if.sv
// Player/board-facing signal bundle of the Genius game engine.
// The board top or testbench is the master. The game core is the slave.
interface genius_core_param_if #(
  parameter int N_BUTTONS = 4,
  parameter int LVL_W     = 4
);
  logic                 start;
  logic [15:0]          seed;
  logic [N_BUTTONS-1:0] btn;
  logic [N_BUTTONS-1:0] sym_led;
  logic [LVL_W-1:0]     level;
  logic [2:0]           phase;
  logic                 busy;
  logic                 win;
  logic                 lose;

  modport master (
    output start, seed, btn,
    input  sym_led, level, phase, busy, win, lose
  );

  modport slave (
    input  start, seed, btn,
    output sym_led, level, phase, busy, win, lose
  );
endinterface

// File: rtl/genius_core_param.sv
// Genius/Simon game engine: LFSR-generated sequence, timed replay, timed player input check.
// The sequence is regenerated from the stored seed on every pass. No sequence memory is used.
module genius_core_param #(
  parameter int N_BUTTONS     = 4,
  parameter int MAX_LEVEL     = 15,
  parameter int SHOW_TICKS    = 25,
  parameter int GAP_TICKS     = 10,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic               clock,
  input  logic               reset,
  genius_core_param_if.slave bus
);

  localparam int SYM_W    = $clog2(N_BUTTONS);
  localparam int LVL_W    = $clog2(MAX_LEVEL + 1);
  localparam int TICK_MAX = (SHOW_TICKS > GAP_TICKS)
                          ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                          : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
  localparam int TICK_W   = $clog2(TICK_MAX + 1);

  localparam logic [TICK_W-1:0] SHOW_LAST    = TICK_W'(SHOW_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST     = TICK_W'(GAP_TICKS - 1);
  localparam logic [TICK_W-1:0] TIMEOUT_LAST = TICK_W'(TIMEOUT_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_SAT     = TICK_W'(TICK_MAX);
  localparam logic [LVL_W-1:0]  LEVEL_TOP    = LVL_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_t;

  state_t               state, state_d;
  logic [15:0]          seed_q, seed_d;
  logic [15:0]          lfsr, lfsr_d;
  logic [LVL_W-1:0]     idx, idx_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [TICK_W-1:0]    tick, tick_d;
  logic [N_BUTTONS-1:0] btn_prev;
  logic [N_BUTTONS-1:0] sym_led_q, sym_led_d;
  logic                 busy_q, busy_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;

  logic [15:0]          step_seed;
  logic [15:0]          step_lfsr;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] expect_hot;
  logic [LVL_W:0]       idx_plus;
  logic [TICK_W-1:0]    tick_inc;
  logic                 idx_more;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [N_BUTTONS-1:0] one_hot(input logic [SYM_W-1:0] s);
    logic [N_BUTTONS-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  assign step_seed  = lfsr_step(seed_q);
  assign step_lfsr  = lfsr_step(lfsr);
  assign rise       = bus.btn & ~btn_prev;
  assign expect_hot = one_hot(step_lfsr[SYM_W-1:0]);
  assign idx_plus   = {1'b0, idx} + 1'b1;
  assign idx_more   = idx_plus < {1'b0, level_q};
  assign tick_inc   = (tick == TICK_SAT) ? tick : tick + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      seed_q    <= '0;
      lfsr      <= '0;
      idx       <= '0;
      level_q   <= '0;
      tick      <= '0;
      btn_prev  <= '0;
      sym_led_q <= '0;
      busy_q    <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state     <= state_d;
      seed_q    <= seed_d;
      lfsr      <= lfsr_d;
      idx       <= idx_d;
      level_q   <= level_d;
      tick      <= tick_d;
      btn_prev  <= bus.btn;
      sym_led_q <= sym_led_d;
      busy_q    <= busy_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  always_comb begin
    state_d   = state;
    seed_d    = seed_q;
    lfsr_d    = lfsr;
    idx_d     = idx;
    level_d   = level_q;
    tick_d    = tick_inc;
    sym_led_d = sym_led_q;

    case (state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (bus.start) begin
          seed_d    = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
          level_d   = LVL_W'(1);
          sym_led_d = '0;
          state_d   = ST_LOAD;
        end
      end

      // The LFSR is loaded from the seed and stepped once, so the replay starts with symbol 0.
      ST_LOAD: begin
        lfsr_d    = step_seed;
        idx_d     = '0;
        tick_d    = '0;
        sym_led_d = one_hot(step_seed[SYM_W-1:0]);
        state_d   = ST_SHOW_ON;
      end

      ST_SHOW_ON: begin
        if (tick == SHOW_LAST) begin
          tick_d    = '0;
          sym_led_d = '0;
          state_d   = ST_SHOW_OFF;
        end
      end

      ST_SHOW_OFF: begin
        if (tick == GAP_LAST) begin
          tick_d = '0;
          if (idx_more) begin
            idx_d     = idx + 1'b1;
            lfsr_d    = step_lfsr;
            sym_led_d = one_hot(step_lfsr[SYM_W-1:0]);
            state_d   = ST_SHOW_ON;
          end else begin
            idx_d     = '0;
            lfsr_d    = seed_q;
            sym_led_d = bus.btn;
            state_d   = ST_WAIT_IN;
          end
        end
      end

      // The LFSR holds idx steps, so the expected symbol is one step ahead. A press beats the timeout.
      ST_WAIT_IN: begin
        sym_led_d = bus.btn;
        if (rise != '0) begin
          if (rise == expect_hot) begin
            lfsr_d = step_lfsr;
            tick_d = '0;
            if (idx_more) begin
              idx_d = idx + 1'b1;
            end else if (level_q == LEVEL_TOP) begin
              sym_led_d = '1;
              state_d   = ST_WIN;
            end else begin
              level_d   = level_q + 1'b1;
              sym_led_d = '0;
              state_d   = ST_LOAD;
            end
          end else begin
            sym_led_d = '0;
            state_d   = ST_LOSE;
          end
        end else if (tick == TIMEOUT_LAST) begin
          sym_led_d = '0;
          state_d   = ST_LOSE;
        end
      end

      default: begin
        sym_led_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_SHOW_ON) ||
             (state_d == ST_SHOW_OFF) || (state_d == ST_WAIT_IN);
    win_d  = (state_d == ST_WIN);
    lose_d = (state_d == ST_LOSE);
  end

  assign bus.phase   = state;
  assign bus.level   = level_q;
  assign bus.sym_led = sym_led_q;
  assign bus.busy    = busy_q;
  assign bus.win     = win_q;
  assign bus.lose    = lose_q;

endmodule

// File: tb/tb_genius_core_param.sv
// Directed bench for genius_core_param (4 buttons, 3 levels, short timings).
// Expected symbols are hand-computed from the LFSR: seed 1234 gives 2,1,2 and seed ACE1 gives 0,0,0.
module tb_genius_core_param;

  localparam int N_BUTTONS     = 4;
  localparam int MAX_LEVEL     = 3;
  localparam int SHOW_TICKS    = 4;
  localparam int GAP_TICKS     = 2;
  localparam int TIMEOUT_TICKS = 20;
  localparam int LVL_W         = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [1:0] seq_sym [0:2];

  genius_core_param_if #(.N_BUTTONS(N_BUTTONS), .LVL_W(LVL_W)) bus ();

  genius_core_param #(
    .N_BUTTONS    (N_BUTTONS),
    .MAX_LEVEL    (MAX_LEVEL),
    .SHOW_TICKS   (SHOW_TICKS),
    .GAP_TICKS    (GAP_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Packs {phase, level, sym_led, busy, win, lose} so one comparison covers every output.
  task automatic checkState(input string tag, input logic [2:0] ph, input logic [1:0] lv, input logic [3:0] led);
    logic busy_e, win_e, lose_e;
    busy_e = (ph >= 3'd1) && (ph <= 3'd4);
    win_e  = (ph == 3'd5);
    lose_e = (ph == 3'd6);
    checkOutput(tag,
                {20'd0, bus.phase, bus.level, bus.sym_led, bus.busy, bus.win, bus.lose},
                {20'd0, ph, lv, led, busy_e, win_e, lose_e});
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] sd, input logic [3:0] b);
    bus.start = s;
    bus.seed  = sd;
    bus.btn   = b;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] oneHot(input logic [1:0] s);
    logic [3:0] r;
    r    = 4'b0000;
    r[s] = 1'b1;
    return r;
  endfunction

  task automatic startGame(input logic [15:0] sd);
    applyStimulus(1'b1, sd, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    checkState("load", 3'd1, 2'd1, 4'b0000);
    stepCycle();
  endtask

  task automatic runReplay(input int n, input logic [1:0] lv, input logic [3:0] entry_led);
    for (int k = 0; k < n; k++) begin
      repeat (SHOW_TICKS) begin
        checkState("replay_on", 3'd2, lv, oneHot(seq_sym[k]));
        stepCycle();
      end
      repeat (GAP_TICKS) begin
        checkState("replay_off", 3'd3, lv, 4'b0000);
        stepCycle();
      end
    end
    checkState("wait_entry", 3'd4, lv, entry_led);
  endtask

  task automatic pressKey(input logic [3:0] b);
    bus.btn = b;
    stepCycle();
    bus.btn = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    reset = 1'b0;
    repeat (3) stepCycle();
    checkState("reset", 3'd0, 2'd0, 4'b0000);
    reset = 1'b1;
    stepCycle();
    checkState("idle", 3'd0, 2'd0, 4'b0000);

    seq_sym = '{2'd2, 2'd1, 2'd2};
    startGame(16'h1234);
    runReplay(1, 2'd1, 4'b0000);
    pressKey(4'b0100);
    checkState("l1_done", 3'd1, 2'd2, 4'b0000);
    stepCycle();
    runReplay(2, 2'd2, 4'b0000);
    pressKey(4'b0100);
    checkState("l2_p0_echo", 3'd4, 2'd2, 4'b0100);
    stepCycle();
    checkState("echo_release", 3'd4, 2'd2, 4'b0000);
    pressKey(4'b0010);
    checkState("l2_done", 3'd1, 2'd3, 4'b0000);
    stepCycle();
    runReplay(3, 2'd3, 4'b0000);
    pressKey(4'b0100);
    checkState("l3_p0", 3'd4, 2'd3, 4'b0100);
    stepCycle();
    pressKey(4'b0010);
    checkState("l3_p1", 3'd4, 2'd3, 4'b0010);
    stepCycle();
    pressKey(4'b0100);
    checkState("win", 3'd5, 2'd3, 4'b1111);
    stepCycle();
    checkState("win_hold", 3'd5, 2'd3, 4'b1111);

    startGame(16'h1234);
    runReplay(1, 2'd1, 4'b0000);
    pressKey(4'b0100);
    checkState("g2_l1_done", 3'd1, 2'd2, 4'b0000);
    stepCycle();
    runReplay(2, 2'd2, 4'b0000);
    pressKey(4'b0100);
    checkState("g2_p0", 3'd4, 2'd2, 4'b0100);
    stepCycle();
    pressKey(4'b0001);
    checkState("wrong_bit", 3'd6, 2'd2, 4'b0000);

    startGame(16'h1234);
    runReplay(1, 2'd1, 4'b0000);
    repeat (TIMEOUT_TICKS - 1) stepCycle();
    checkState("timeout_edge", 3'd4, 2'd1, 4'b0000);
    bus.btn = 4'b0100;
    stepCycle();
    checkState("late_press", 3'd1, 2'd2, 4'b0000);
    stepCycle();
    runReplay(2, 2'd2, 4'b0100);
    repeat (TIMEOUT_TICKS - 1) stepCycle();
    checkState("held_no_event", 3'd4, 2'd2, 4'b0100);
    stepCycle();
    checkState("timeout", 3'd6, 2'd2, 4'b0000);
    bus.btn = 4'b0000;
    stepCycle();

    startGame(16'h1234);
    runReplay(1, 2'd1, 4'b0000);
    pressKey(4'b0110);
    checkState("double_rise", 3'd6, 2'd1, 4'b0000);

    seq_sym = '{2'd0, 2'd0, 2'd0};
    startGame(16'h0000);
    runReplay(1, 2'd1, 4'b0000);
    pressKey(4'b0001);
    checkState("s0_l1_done", 3'd1, 2'd2, 4'b0000);
    stepCycle();
    runReplay(2, 2'd2, 4'b0000);
    pressKey(4'b0001);
    checkState("s0_l2_p0", 3'd4, 2'd2, 4'b0001);
    stepCycle();
    pressKey(4'b0001);
    checkState("s0_l2_done", 3'd1, 2'd3, 4'b0000);
    stepCycle();
    runReplay(3, 2'd3, 4'b0000);
    pressKey(4'b0001);
    stepCycle();
    pressKey(4'b0001);
    stepCycle();
    pressKey(4'b0001);
    checkState("s0_win", 3'd5, 2'd3, 4'b1111);

    seq_sym = '{2'd2, 2'd1, 2'd2};
    startGame(16'h1234);
    checkState("show_first", 3'd2, 2'd1, 4'b0100);
    applyStimulus(1'b1, 16'hACE1, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    checkState("start_ignored", 3'd2, 2'd1, 4'b0100);
    #2;
    reset = 1'b0;
    #1;
    checkState("async_reset", 3'd0, 2'd0, 4'b0000);
    stepCycle();
    reset = 1'b1;
    stepCycle();
    checkState("post_reset", 3'd0, 2'd0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
